// File: rtl/clk_div_cfg_pkg.sv
// Shared types and constants for the divider configuration front-end.
package clk_div_pkg;

  // Controller states; SETTLE is also the post-reset state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    HOLD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // Ratio 0 underflows the divider compare and 1 sticks its output low.
  localparam int MIN_DIV          = 2;
  localparam int DEF_WIDTH        = 7;
  localparam int DEF_DIV          = 4;
  localparam int DEF_HOLD_CYCLES  = 2;
  localparam int DEF_LOCK_PERIODS = 2;

  // A ratio is legal when it is not below the minimum the divider tolerates.
  function automatic logic ratio_legal(input int unsigned ratio, input int unsigned min_div);
    return ratio >= min_div;
  endfunction

endpackage

// File: rtl/clk_div_cfg_if.sv
// Request/status bundle between a ratio requester and the configuration block.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_div is only meaningful at that edge. A valid
// raised while req_ready is low is ignored, not queued.
interface clk_div_cfg_if #(
  parameter int WIDTH = 7
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_div;
  logic [WIDTH-1:0] div_num;
  logic             div_rst;
  logic [WIDTH-1:0] phase;
  logic             locked;
  logic             cfg_done;
  logic             cfg_err;

  modport master (
    output req_valid, req_div,
    input  req_ready, div_num, div_rst, phase, locked, cfg_done, cfg_err
  );

  modport slave (
    input  req_valid, req_div,
    output req_ready, div_num, div_rst, phase, locked, cfg_done, cfg_err
  );
endinterface

// File: rtl/clk_div_cfg_div_phase_ctr.sv
// Shadow of the divider's rising-edge counter: counts 0..div_num-1 and wraps,
// held at 0 while clr_i is high. wrap_o marks the last phase of a period.
module div_phase_ctr #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] div_num_i,
  output logic [WIDTH-1:0] phase_o,
  output logic             wrap_o
);
  logic [WIDTH-1:0] phase_q;
  logic [WIDTH-1:0] phase_d;
  logic             at_last;

  // div_num_i is never below 2, so the subtraction cannot underflow.
  assign at_last = (phase_q == (div_num_i - WIDTH'(1)));
  assign wrap_o  = at_last && !clr_i;
  assign phase_o = phase_q;

  // Next phase: clear, wrap to zero after the last phase, or count up.
  always_comb begin
    phase_d = phase_q + WIDTH'(1);
    if (clr_i || at_last) phase_d = '0;
  end

  // Phase register.
  always_ff @(posedge clk) begin
    phase_q <= phase_d;
  end
endmodule

// File: rtl/clk_div_cfg.sv
// Configuration front-end for the runtime clock divider: accepts new ratios,
// swaps them in at a period boundary, clears the divider counters, and reports
// lock after a number of clean output periods.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int DEFAULT_DIV  = DEF_DIV,
  parameter int MIN_DIV      = clk_div_pkg::MIN_DIV,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int LOCK_PERIODS = DEF_LOCK_PERIODS
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_cfg_if.slave cfg,
  output state_t       state_o
);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam int WCW = $clog2(LOCK_PERIODS + 1);

  if (DEFAULT_DIV < MIN_DIV || DEFAULT_DIV > (1 << WIDTH) - 1) begin : g_bad_default
    $error("clk_div_cfg: DEFAULT_DIV out of legal range");
  end
  if (MIN_DIV < 2 || HOLD_CYCLES < 1 || LOCK_PERIODS < 1) begin : g_bad_param
    $error("clk_div_cfg: MIN_DIV >= 2, HOLD_CYCLES >= 1, LOCK_PERIODS >= 1 required");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] req_q, req_d;
  logic [WIDTH-1:0] div_num_q, div_num_d;
  logic             div_rst_q, div_rst_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [WCW-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic             pend_q, pend_d;
  logic             cfg_done_q, cfg_done_d;
  logic             cfg_err_q, cfg_err_d;

  logic             req_ready;
  logic             locked;
  logic             handshake;
  logic             req_legal;
  logic             req_same;
  logic             wrap;
  logic             last_wrap;
  logic [WIDTH-1:0] phase;

  div_phase_ctr #(.WIDTH(WIDTH)) u_phase (
    .clk       (clk),
    .clr_i     (reset || div_rst_q),
    .div_num_i (div_num_q),
    .phase_o   (phase),
    .wrap_o    (wrap)
  );

  assign handshake = cfg.req_valid && req_ready;
  assign req_legal = ratio_legal(32'(cfg.req_div), MIN_DIV);
  assign req_same  = (cfg.req_div == div_num_q);
  assign last_wrap = (wrap_cnt_q == WCW'(LOCK_PERIODS - 1));

  // State register; reset lands in SETTLE so the default ratio is proven first.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SETTLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (handshake && req_legal && !req_same) state_d = DRAIN;
      DRAIN:  if (wrap) state_d = HOLD;
      HOLD:   if (hold_cnt_q == '0) state_d = SETTLE;
      SETTLE: if (wrap && last_wrap) state_d = IDLE;
    endcase
  end

  // Moore outputs: ready only in IDLE, lock lost from HOLD until settled.
  always_comb begin
    req_ready = 1'b0;
    locked    = 1'b0;
    unique case (state_q)
      IDLE:    begin req_ready = 1'b1; locked = 1'b1; end
      DRAIN:   locked = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: request capture, ratio swap, hold and wrap counting.
  always_comb begin
    req_d      = req_q;
    div_num_d  = div_num_q;
    div_rst_d  = div_rst_q;
    hold_cnt_d = hold_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    pend_d     = pend_q;
    cfg_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (handshake) begin
          req_d = cfg.req_div;
          if (!req_legal)    cfg_err_d  = 1'b1;
          else if (req_same) cfg_done_d = 1'b1;
          else               pend_d     = 1'b1;
        end
      end
      DRAIN: begin
        // Swap only at a period boundary so no truncated output period escapes.
        if (wrap) begin
          div_num_d  = req_q;
          div_rst_d  = 1'b1;
          hold_cnt_d = HCW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          div_rst_d  = 1'b0;
          wrap_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HCW'(1);
        end
      end
      SETTLE: begin
        if (wrap) begin
          if (last_wrap) begin
            cfg_done_d = pend_q;
            pend_d     = 1'b0;
          end else begin
            wrap_cnt_d = wrap_cnt_q + WCW'(1);
          end
        end
      end
    endcase
  end

  // Datapath registers; reset drops any pending request silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q      <= '0;
      div_num_q  <= WIDTH'(DEFAULT_DIV);
      div_rst_q  <= 1'b0;
      hold_cnt_q <= '0;
      wrap_cnt_q <= '0;
      pend_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      req_q      <= req_d;
      div_num_q  <= div_num_d;
      div_rst_q  <= div_rst_d;
      hold_cnt_q <= hold_cnt_d;
      wrap_cnt_q <= wrap_cnt_d;
      pend_q     <= pend_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg.req_ready = req_ready;
  assign cfg.div_num   = div_num_q;
  assign cfg.div_rst   = div_rst_q;
  assign cfg.phase     = phase;
  assign cfg.locked    = locked;
  assign cfg.cfg_done  = cfg_done_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_clk_div_cfg.sv
// Directed bench for clk_div_cfg; all expectations are hand-derived cycle by cycle.
module tb_clk_div_cfg;
  import clk_div_pkg::*;

  logic   clk;
  logic   reset;
  state_t state;
  int     n_cmp;
  int     n_err;

  clk_div_cfg_if #(.WIDTH(7)) bus ();

  clk_div_cfg #(
    .WIDTH(7), .DEFAULT_DIV(4), .MIN_DIV(2), .HOLD_CYCLES(2), .LOCK_PERIODS(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg     (bus),
    .state_o (state)
  );

  // Clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_div_num"},  32'(bus.div_num), 32'd4);
    check({tag, "_div_rst"},  32'(bus.div_rst), 32'd0);
    check({tag, "_phase"},    32'(bus.phase), 32'd0);
    check({tag, "_locked"},   32'(bus.locked), 32'd0);
    check({tag, "_done"},     32'(bus.cfg_done), 32'd0);
    check({tag, "_err"},      32'(bus.cfg_err), 32'd0);
    check({tag, "_ready"},    32'(bus.req_ready), 32'd0);
    check({tag, "_state"},    32'(state), 32'(SETTLE));
  endtask

  // Eight settle cycles at ratio 4, then locked with no completion pulse.
  task automatic check_default_lock(input string tag);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_locked_lo"}, 32'(bus.locked), 32'd0);
      check({tag, "_ready_lo"},  32'(bus.req_ready), 32'd0);
      check({tag, "_no_done"},   32'(bus.cfg_done), 32'd0);
      check({tag, "_phase"},     32'(bus.phase), 32'(i % 4));
      tick(1);
    end
    check({tag, "_locked"},  32'(bus.locked), 32'd1);
    check({tag, "_ready"},   32'(bus.req_ready), 32'd1);
    check({tag, "_no_done"}, 32'(bus.cfg_done), 32'd0);
    check({tag, "_state"},   32'(state), 32'(IDLE));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_div   = '0;
    tick(3);

    // Reset values, then release and watch the default ratio lock.
    check_reset_vals("rst");
    reset = 1'b0;
    check_default_lock("boot");

    // Illegal ratios 0 and 1 are rejected with a one-cycle error pulse.
    bus.req_valid = 1'b1; bus.req_div = 7'd0;
    tick(1);
    check("err0_pulse", 32'(bus.cfg_err), 32'd1);
    check("err0_done",  32'(bus.cfg_done), 32'd0);
    check("err0_div",   32'(bus.div_num), 32'd4);
    check("err0_state", 32'(state), 32'(IDLE));
    check("err0_phase", 32'(bus.phase), 32'd1);
    bus.req_valid = 1'b0;
    tick(1);
    check("err0_clear", 32'(bus.cfg_err), 32'd0);
    bus.req_valid = 1'b1; bus.req_div = 7'd1;
    tick(1);
    check("err1_pulse", 32'(bus.cfg_err), 32'd1);
    check("err1_div",   32'(bus.div_num), 32'd4);
    bus.req_valid = 1'b0;
    tick(1);
    check("err1_clear",  32'(bus.cfg_err), 32'd0);
    check("err1_divrst", 32'(bus.div_rst), 32'd0);
    check("err1_locked", 32'(bus.locked), 32'd1);
    check("err1_phase",  32'(bus.phase), 32'd0);

    // Same ratio: immediate completion, phase keeps running.
    bus.req_valid = 1'b1; bus.req_div = 7'd4;
    tick(1);
    check("same_done",   32'(bus.cfg_done), 32'd1);
    check("same_err",    32'(bus.cfg_err), 32'd0);
    check("same_divrst", 32'(bus.div_rst), 32'd0);
    check("same_phase",  32'(bus.phase), 32'd1);
    check("same_state",  32'(state), 32'(IDLE));
    bus.req_valid = 1'b0;
    tick(1);
    check("same_clear", 32'(bus.cfg_done), 32'd0);
    check("same_phase2", 32'(bus.phase), 32'd2);

    // Ratio 10 requested while phase==1.
    tick(3);
    check("r10_start_phase", 32'(bus.phase), 32'd1);
    bus.req_valid = 1'b1; bus.req_div = 7'd10;
    tick(1);
    check("r10_drain",  32'(state), 32'(DRAIN));
    check("r10_ready",  32'(bus.req_ready), 32'd0);
    check("r10_locked", 32'(bus.locked), 32'd1);
    check("r10_phase2", 32'(bus.phase), 32'd2);
    bus.req_valid = 1'b0; bus.req_div = 7'd0;
    tick(1);
    check("r10_phase3", 32'(bus.phase), 32'd3);
    check("r10_rst_lo", 32'(bus.div_rst), 32'd0);
    check("r10_div_old", 32'(bus.div_num), 32'd4);
    tick(1);
    check("r10_hold",    32'(state), 32'(HOLD));
    check("r10_rst_hi1", 32'(bus.div_rst), 32'd1);
    check("r10_div_new", 32'(bus.div_num), 32'd10);
    check("r10_unlock",  32'(bus.locked), 32'd0);
    check("r10_ph_clr",  32'(bus.phase), 32'd0);
    tick(1);
    check("r10_rst_hi2", 32'(bus.div_rst), 32'd1);
    check("r10_ph_clr2", 32'(bus.phase), 32'd0);
    tick(1);
    check("r10_rst_fall", 32'(bus.div_rst), 32'd0);
    check("r10_settle",   32'(state), 32'(SETTLE));
    for (int i = 0; i < 20; i++) begin
      check("r10_set_phase",  32'(bus.phase), 32'(i % 10));
      check("r10_set_locked", 32'(bus.locked), 32'd0);
      check("r10_set_done",   32'(bus.cfg_done), 32'd0);
      tick(1);
    end
    check("r10_done",   32'(bus.cfg_done), 32'd1);
    check("r10_lock",   32'(bus.locked), 32'd1);
    check("r10_rdy",    32'(bus.req_ready), 32'd1);
    check("r10_idle",   32'(state), 32'(IDLE));
    check("r10_ph0",    32'(bus.phase), 32'd0);
    check("r10_divnum", 32'(bus.div_num), 32'd10);
    tick(1);
    check("r10_done_pulse", 32'(bus.cfg_done), 32'd0);
    check("r10_ph1",        32'(bus.phase), 32'd1);

    // Ratio 127, then valid held high with ratio 6 through the whole sequence.
    bus.req_valid = 1'b1; bus.req_div = 7'd127;
    tick(1);
    check("r127_drain", 32'(state), 32'(DRAIN));
    check("r127_ph2",   32'(bus.phase), 32'd2);
    bus.req_div = 7'd6;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      check("r127_drain_wait", 32'(state), 32'(DRAIN));
      check("r127_ignored",    32'(bus.req_ready), 32'd0);
    end
    check("r127_ph9", 32'(bus.phase), 32'd9);
    tick(1);
    check("r127_hold",   32'(state), 32'(HOLD));
    check("r127_div",    32'(bus.div_num), 32'd127);
    check("r127_rst_hi", 32'(bus.div_rst), 32'd1);
    tick(2);
    check("r127_rst_lo", 32'(bus.div_rst), 32'd0);
    for (int i = 0; i < 254; i++) begin
      check("r127_set_phase", 32'(bus.phase), 32'(i % 127));
      check("r127_set_ready", 32'(bus.req_ready), 32'd0);
      check("r127_set_done",  32'(bus.cfg_done), 32'd0);
      tick(1);
    end
    check("r127_done", 32'(bus.cfg_done), 32'd1);
    check("r127_lock", 32'(bus.locked), 32'd1);
    check("r127_idle", 32'(state), 32'(IDLE));
    check("r127_rdy",  32'(bus.req_ready), 32'd1);
    tick(1);
    check("r6_accepted", 32'(state), 32'(DRAIN));
    check("r6_done_lo",  32'(bus.cfg_done), 32'd0);
    check("r6_ph1",      32'(bus.phase), 32'd1);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 125; i++) begin
      tick(1);
      check("r6_drain_wait", 32'(bus.div_rst), 32'd0);
    end
    check("r6_ph126",    32'(bus.phase), 32'd126);
    check("r6_drain",    32'(state), 32'(DRAIN));
    tick(1);
    check("r6_hold",     32'(state), 32'(HOLD));
    check("r6_div",      32'(bus.div_num), 32'd6);
    check("r6_rst_hi",   32'(bus.div_rst), 32'd1);
    tick(2);
    check("r6_settle",   32'(state), 32'(SETTLE));
    for (int i = 0; i < 12; i++) begin
      check("r6_set_phase",  32'(bus.phase), 32'(i % 6));
      check("r6_set_locked", 32'(bus.locked), 32'd0);
      tick(1);
    end
    check("r6_done", 32'(bus.cfg_done), 32'd1);
    check("r6_lock", 32'(bus.locked), 32'd1);

    // Ratio 9 aborted by reset during HOLD.
    bus.req_valid = 1'b1; bus.req_div = 7'd9;
    tick(1);
    check("r9_drain", 32'(state), 32'(DRAIN));
    check("r9_ph1",   32'(bus.phase), 32'd1);
    bus.req_valid = 1'b0;
    tick(4);
    check("r9_ph5", 32'(bus.phase), 32'd5);
    tick(1);
    check("r9_hold",   32'(state), 32'(HOLD));
    check("r9_div",    32'(bus.div_num), 32'd9);
    check("r9_rst_hi", 32'(bus.div_rst), 32'd1);
    reset = 1'b1;
    tick(1);
    check_reset_vals("r9_abort");
    reset = 1'b0;
    check_default_lock("r9_relock");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
